sliding_window_gen: RTL and testbench
=====================================

// Module: sliding_window_gen
// PURPOSE
//  Streaming KxK pixel-window generator with on-chip line buffers, row/col tracking and frame sequencing.
//  Accepts one raster-order pixel per handshake and emits one complete KxK window per output handshake.
//  Sits between the pixel input path and the arithmetic kernel; replaces the fixed clear-on-row-switch shift matrix.
//  Generalised in kernel size, pixel width and maximum line length, and adds valid/ready flow control.
// PARAMETERS
//  PIX_W     8     bits per pixel
//  KSIZE     3     window edge (odd, 3..17); KSIZE-1 line buffers of MAX_COLS entries each
//  MAX_COLS  1024  largest supported image width
//  DIM_W     16    width of all dimension/position fields
// PORTS
//  clk        in   1                  clock, all logic rising-edge
//  rst        in   1                  asynchronous active-high reset
//  cfg_load   in   1                  latch cfg_cols/cfg_rows and start a frame (honoured in IDLE only)
//  cfg_cols   in   DIM_W              image width in pixels
//  cfg_rows   in   DIM_W              image height in pixels
//  s_valid    in   1                  input pixel valid
//  s_ready    out  1                  input pixel accepted when s_valid&&s_ready
//  s_pixel    in   PIX_W              input pixel, raster order
//  m_valid    out  1                  window valid
//  m_ready    in   1                  window consumed when m_valid&&m_ready
//  m_window   out  KSIZE*KSIZE*PIX_W  [PIX_W*(r*KSIZE+c) +: PIX_W] = window row r (0=top), col c (0=left)
//  m_col      out  DIM_W              window column position
//  m_row      out  DIM_W              window row position
//  frame_done out  1                  1-cycle pulse on handshake of last window of frame
//  busy       out  1                  high in RUN/FLUSH
//  cfg_err    out  1                  1-cycle pulse on rejected cfg_load
// BEHAVIOUR
//  Reset: state=IDLE; s_ready, m_valid, frame_done, busy, cfg_err = 0; m_window, m_col, m_row = 0; counters 0.
//   Line-buffer RAM is not cleared; stale contents are never emitted (masked by counters).
//  FSM IDLE -> RUN on cfg_load with KSIZE<=cfg_cols<=MAX_COLS and cfg_rows>=KSIZE; otherwise cfg_err pulses, stay IDLE.
//   cfg_load outside IDLE is ignored (no error).
//  RUN: s_ready = !m_valid || m_ready (single output register stage; zero-bubble at full rate).
//   Each accepted pixel: write into line buffer at in_col; shift window columns left; new right column =
//   {line buffers oldest..newest, s_pixel}; in_col++ wraps to 0 at cfg_cols-1 with in_row++.
//  Window emit: registered; m_valid rises cycle after the triggering input handshake; holds m_window/m_col/m_row
//   stable while m_valid && !m_ready. m_valid clears on handshake unless a new window loads in the same cycle.
//  Last input pixel accepted -> FLUSH (ZERO_PAD_EN) or DRAIN wait; return to IDLE when last window handshakes,
//   with frame_done pulsing that cycle; busy drops the following cycle.
//  s_valid while IDLE/FLUSH: not accepted (s_ready=0).
//  rst mid-frame: immediate abort to reset values; a new cfg_load is required.
// CONFIGURATION
//  ZERO_PAD_EN undefined: valid-only windows. Emit when in_row>=KSIZE-1 && in_col>=KSIZE-1;
//   m_col/m_row = top-left coordinate; (cfg_cols-KSIZE+1)*(cfg_rows-KSIZE+1) windows per frame.
//  ZERO_PAD_EN defined: same-size output, zero border. m_col/m_row = centre coordinate (H=KSIZE/2);
//   cfg_cols*cfg_rows windows. Window taps outside the image (row<0, row>=rows, col<0, col>=cols) read 0,
//   including columns that would wrap across a line. FLUSH injects H*cfg_cols+H internal zero pixels,
//   one per free output slot (same !m_valid||m_ready rule), to complete the last rows.
// TESTING
//  K=3, cols=4, rows=3, pixels 0..11, m_ready=1 -> 2 windows; first {0,1,2,4,5,6,8,9,10} col0 row0;
//   second {1,2,3,5,6,7,9,10,11} col1 row0; frame_done with second.
//  Same frame, m_ready toggling 1-in-3, s_valid=1 throughout -> identical window sequence, no drops,
//   m_window stable while stalled, s_ready=0 while output held.
//  cfg_load with cfg_cols=2 (or rows=2, or cols=MAX_COLS+1) -> cfg_err 1-cycle pulse, busy stays 0, s_ready 0.
//  rst asserted after 6 pixels of the first frame -> all outputs at reset values next edge; new cfg_load
//   plus full frame reproduces test 1 exactly.
//  ZERO_PAD_EN, K=3, 4x3 ramp -> 12 windows; first {0,0,0,0,0,1,0,4,5} centre (0,0);
//   last {6,7,0,10,11,0,0,0,0} centre (3,2); frame_done on last.
//  Back-to-back frames: cfg_load the cycle after frame_done -> accepted, second frame windows correct, no carryover.

Source files
------------

// File: rtl/sliding_window_gen.sv
// sliding_window_gen: streaming KxK pixel-window generator with line buffers and frame sequencing.
//
// Accepts one raster-order pixel per s_valid/s_ready handshake and emits one complete KxK window
// per m_valid/m_ready handshake through a single registered output stage (zero-bubble at full rate).
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   cfg_load            latch cfg_cols/cfg_rows and start a frame (honoured in IDLE only)
//   cfg_cols, cfg_rows  image width/height in pixels
//   s_valid/s_ready     input pixel handshake, s_pixel carries the pixel
//   m_valid/m_ready     output window handshake
//   m_window            [PIX_W*(r*KSIZE+c) +: PIX_W] = window row r (0=top), col c (0=left)
//   m_col, m_row        window position (top-left, or centre when zero padding is enabled)
//   frame_done          1-cycle pulse on the handshake of the last window of a frame
//   busy                high while a frame is in progress
//   cfg_err             1-cycle pulse after a rejected cfg_load
//
// Build option ZERO_PAD_EN: when defined, same-size output with a zero border and centre
// coordinates; when undefined, only windows fully inside the image are emitted.
module sliding_window_gen #(
   parameter int PIX_W    = 8,
   parameter int KSIZE    = 3,
   parameter int MAX_COLS = 1024,
   parameter int DIM_W    = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cfg_load,
   input  logic [DIM_W-1:0]               cfg_cols,
   input  logic [DIM_W-1:0]               cfg_rows,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [PIX_W-1:0]               s_pixel,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [KSIZE*KSIZE*PIX_W-1:0]   m_window,
   output logic [DIM_W-1:0]               m_col,
   output logic [DIM_W-1:0]               m_row,
   output logic                           frame_done,
   output logic                           busy,
   output logic                           cfg_err
);

   localparam int CW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
   localparam logic [DIM_W-1:0] ONE_D  = DIM_W'(1);
   localparam logic [DIM_W-1:0] K_D    = DIM_W'(KSIZE);
   localparam logic [DIM_W-1:0] K1_D   = DIM_W'(KSIZE - 1);
   localparam logic [DIM_W-1:0] MAXC_D = DIM_W'(MAX_COLS);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

`ifdef ZERO_PAD_EN
   localparam int H = KSIZE / 2;
   localparam logic [DIM_W-1:0] H_D  = DIM_W'(H);
   localparam logic [DIM_W-1:0] H1_D = DIM_W'(H - 1);
   localparam logic signed [DIM_W+1:0] HS  = (DIM_W+2)'(H);
   localparam logic signed [DIM_W+1:0] HS1 = (DIM_W+2)'(H + 1);
   localparam logic [1:0] TAIL = FLUSH;
`else
   localparam logic [1:0] TAIL = DRAIN;
`endif

   logic [1:0]             state;
   logic [DIM_W-1:0]       cols, rows, in_col, in_row;
   logic [PIX_W-1:0]       lb [KSIZE-1][MAX_COLS];
   logic [PIX_W-1:0]       win [KSIZE][KSIZE];
   logic [PIX_W-1:0]       nwin [KSIZE][KSIZE];
   logic [PIX_W-1:0]       col_new [KSIZE];
   logic [KSIZE*KSIZE*PIX_W-1:0] owin;
   logic [CW-1:0]          addr;
   logic [PIX_W-1:0]       pix;
   logic [DIM_W-1:0]       e_col, e_row;
   logic                   slot_free, accept, wrap, last_in, last_win, emit, cfg_ok, m_last;

   assign busy       = state != IDLE;
   assign frame_done = m_valid && m_ready && m_last;
   assign addr       = in_col[CW-1:0];
   assign cfg_ok     = cfg_cols >= K_D && cfg_cols <= MAXC_D && cfg_rows >= K_D;

   // FLUSH feeds internal zero pixels using the same free-slot rule as real input.
   always_comb begin
      slot_free = !m_valid || m_ready;
      s_ready   = state == RUN && slot_free;
      accept    = (state == RUN && s_valid && slot_free) || (state == FLUSH && slot_free);
      pix       = state == RUN ? s_pixel : '0;
      wrap      = in_col == cols - ONE_D;
      last_in   = state == RUN && wrap && in_row == rows - ONE_D;
   end

   // New right-hand column: line buffers oldest (top) to newest, then the incoming pixel.
   always_comb begin
      for (int r = 0; r < KSIZE - 1; r++)
         col_new[r] = lb[r][addr];
      col_new[KSIZE-1] = pix;
      for (int r = 0; r < KSIZE; r++) begin
         for (int c = 0; c < KSIZE - 1; c++)
            nwin[r][c] = win[r][c+1];
         nwin[r][KSIZE-1] = col_new[r];
      end
   end

`ifdef ZERO_PAD_EN
   logic signed [DIM_W+1:0] cc, cr;

   function automatic logic tap_ok(input logic signed [DIM_W+1:0] y, x, lim_y, lim_x);
      return !y[DIM_W+1] && !x[DIM_W+1] && y < lim_y && x < lim_x;
   endfunction

   // The stream is treated as one long line, so the window centre trails the newest pixel by
   // H rows and H columns; a centre column below H belongs to the end of the previous row.
   always_comb begin
      cc       = (in_col >= H_D) ? $signed({2'b0, in_col}) - HS
                                 : $signed({2'b0, in_col}) + $signed({2'b0, cols}) - HS;
      cr       = $signed({2'b0, in_row}) - ((in_col >= H_D) ? HS : HS1);
      emit     = !cr[DIM_W+1];
      e_col    = cc[DIM_W-1:0];
      e_row    = cr[DIM_W-1:0];
      last_win = state == FLUSH && in_col == H1_D && in_row == rows + H_D;
   end

   // Taps outside the image (including those wrapped across a line) are forced to zero.
   always_comb begin
      owin = '0;
      for (int r = 0; r < KSIZE; r++)
         for (int c = 0; c < KSIZE; c++)
            owin[PIX_W*(r*KSIZE+c) +: PIX_W] =
               tap_ok(cr + (DIM_W+2)'(r) - HS, cc + (DIM_W+2)'(c) - HS,
                      $signed({2'b0, rows}), $signed({2'b0, cols})) ? nwin[r][c] : '0;
   end
`else
   always_comb begin
      emit     = in_row >= K1_D && in_col >= K1_D;
      e_col    = in_col - K1_D;
      e_row    = in_row - K1_D;
      last_win = last_in;
   end

   always_comb begin
      owin = '0;
      for (int r = 0; r < KSIZE; r++)
         for (int c = 0; c < KSIZE; c++)
            owin[PIX_W*(r*KSIZE+c) +: PIX_W] = nwin[r][c];
   end
`endif

   // Line buffers form a chain of one-line delays; contents are never cleared because
   // the position counters mask anything left over from an earlier frame.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < KSIZE - 2; r++)
            lb[r][addr] <= lb[r+1][addr];
         lb[KSIZE-2][addr] <= pix;
         for (int r = 0; r < KSIZE; r++)
            for (int c = 0; c < KSIZE; c++)
               win[r][c] <= nwin[r][c];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cols     <= '0;
         rows     <= '0;
         in_col   <= '0;
         in_row   <= '0;
         m_valid  <= 1'b0;
         m_window <= '0;
         m_col    <= '0;
         m_row    <= '0;
         m_last   <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_err <= state == IDLE && cfg_load && !cfg_ok;
         if (state == IDLE && cfg_load && cfg_ok) begin
            state  <= RUN;
            cols   <= cfg_cols;
            rows   <= cfg_rows;
            in_col <= '0;
            in_row <= '0;
         end
         if (accept) begin
            in_col <= wrap ? '0 : in_col + ONE_D;
            in_row <= wrap ? in_row + ONE_D : in_row;
         end
         if (accept && last_in)
            state <= TAIL;
         if (accept && state == FLUSH && last_win)
            state <= DRAIN;
         if (frame_done)
            state <= IDLE;
         if (accept && emit) begin
            m_valid  <= 1'b1;
            m_window <= owin;
            m_col    <= e_col;
            m_row    <= e_row;
            m_last   <= last_win;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sliding_window_gen.sv
// tb_sliding_window_gen: directed self-checking bench for sliding_window_gen (K=3, MAX_COLS=16).
module tb_sliding_window_gen;

   localparam int PW = 8;
   localparam int K  = 3;
   localparam int MC = 16;
   localparam int DW = 16;
   localparam int WW = K*K*PW;

`ifdef ZERO_PAD_EN
   localparam logic [WW-1:0] W_FIRST = 72'h05_04_00_01_00_00_00_00_00;
   localparam logic [WW-1:0] W_LAST  = 72'h00_00_00_00_0b_0a_00_07_06;
`else
   localparam logic [WW-1:0] W_FIRST = 72'h0a_09_08_06_05_04_02_01_00;
   localparam logic [WW-1:0] W_LAST  = 72'h0b_0a_09_07_06_05_03_02_01;
`endif

   logic clk = 1'b0, rst = 1'b1, cfg_load = 1'b0;
   logic [DW-1:0] cfg_cols = '0, cfg_rows = '0;
   logic s_valid = 1'b0, s_ready;
   logic [PW-1:0] s_pixel = '0;
   logic m_valid, m_ready = 1'b0;
   logic [WW-1:0] m_window;
   logic [DW-1:0] m_col, m_row;
   logic frame_done, busy, cfg_err;
   logic [WW-1:0] fw, lw;
   int n_assert = 0, n_fail = 0;

   sliding_window_gen #(.PIX_W(PW), .KSIZE(K), .MAX_COLS(MC), .DIM_W(DW)) dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
      .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
      .m_valid(m_valid), .m_ready(m_ready), .m_window(m_window), .m_col(m_col), .m_row(m_row),
      .frame_done(frame_done), .busy(busy), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_assert++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // Reference window: pixel value = base + y*cols + x, zero outside the image.
   function automatic logic [WW-1:0] exp_win(input int x0, y0, cols, rows, base);
      logic [WW-1:0] w = '0;
      int y, x;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++) begin
`ifdef ZERO_PAD_EN
            y = y0 + r - K/2;
            x = x0 + c - K/2;
`else
            y = y0 + r;
            x = x0 + c;
`endif
            if (y >= 0 && y < rows && x >= 0 && x < cols)
               w[PW*(r*K+c) +: PW] = PW'(base + y*cols + x);
         end
      return w;
   endfunction

   task automatic run_frame(input int cols, rows, base, stall,
                            output logic [WW-1:0] first_w, last_w);
      int npx = cols*rows, px = 0, k = 0, cyc = 0, ow, nw;
      logic held = 1'b0;
      logic [WW-1:0] hw = '0;
`ifdef ZERO_PAD_EN
      ow = cols;
      nw = cols*rows;
`else
      ow = cols - 2;
      nw = (cols - 2)*(rows - 2);
`endif
      first_w = '0;
      last_w  = '0;
      cfg_cols = DW'(cols);
      cfg_rows = DW'(rows);
      cfg_load = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
      chk("busy_start", busy, 1);
      while (k < nw && cyc < 400) begin
         s_valid = px < npx;
         s_pixel = PW'(base + px);
         m_ready = stall != 0 ? (cyc % 3 == 2) : 1'b1;
         #1;
         if (held) chk("hold_win", m_window, hw);
         if (m_valid && !m_ready) chk("s_ready_stall", s_ready, 0);
         if (m_valid && m_ready) begin
            chk("win", m_window, exp_win(k % ow, k / ow, cols, rows, base));
            chk("col", m_col, k % ow);
            chk("row", m_row, k / ow);
            chk("frame_done", frame_done, k == nw - 1);
            if (k == 0) first_w = m_window;
            last_w = m_window;
            k++;
         end
         held = m_valid && !m_ready;
         hw = m_window;
         if (s_valid && s_ready) px++;
         cyc++;
         @(negedge clk);
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      chk("window_count", k, nw);
      chk("pixels_taken", px, npx);
      #1;
      chk("busy_end", busy, 0);
      chk("m_valid_end", m_valid, 0);
   endtask

   initial begin
      int bad_cols [3] = '{2, 4, MC + 1};
      int bad_rows [3] = '{3, 2, 3};
      repeat (2) @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_m_window", m_window, 0);
      chk("rst_m_col", m_col, 0);
      chk("rst_m_row", m_row, 0);
      rst = 1'b0;
      @(negedge clk);

      run_frame(4, 3, 0, 0, fw, lw);
      chk("t1_first", fw, W_FIRST);
      chk("t1_last", lw, W_LAST);

      run_frame(4, 3, 0, 1, fw, lw);
      chk("t2_first", fw, W_FIRST);
      chk("t2_last", lw, W_LAST);

      for (int i = 0; i < 3; i++) begin
         cfg_cols = DW'(bad_cols[i]);
         cfg_rows = DW'(bad_rows[i]);
         cfg_load = 1'b1;
         s_valid  = 1'b1;
         @(negedge clk);
         cfg_load = 1'b0;
         chk("cfg_err_pulse", cfg_err, 1);
         chk("cfg_err_busy", busy, 0);
         chk("cfg_err_s_ready", s_ready, 0);
         @(negedge clk);
         chk("cfg_err_clear", cfg_err, 0);
         chk("cfg_err_idle", busy, 0);
         s_valid = 1'b0;
      end

      cfg_cols = 4;
      cfg_rows = 3;
      cfg_load = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
      m_ready  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         s_valid = 1'b1;
         s_pixel = PW'(i);
         @(negedge clk);
      end
      s_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_m_valid", m_valid, 0);
      chk("abort_s_ready", s_ready, 0);
      chk("abort_m_window", m_window, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_still_idle", busy, 0);
      run_frame(4, 3, 0, 0, fw, lw);
      chk("t4_first", fw, W_FIRST);
      chk("t4_last", lw, W_LAST);

      run_frame(4, 3, 100, 0, fw, lw);
      run_frame(3, 3, 50, 1, fw, lw);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
